mem_wb_pipeline_stage: RTL and testbench
========================================

Name: mem_wb_pipeline_stage

Overview:
Pipeline register between the MEM stage and the WB stage of the 32-bit MIPS core. It captures MEM-stage results and selects the write-back value (ALU result, load data or link address PC+4). It presents one entry per cycle to the register-file write port. A two-entry skid buffer with a valid/ready handshake lets the WB side stall without a combinational ready path back into MEM. A synchronous flush discards in-flight entries.

Parameters:
NBits, 32, datapath width of ALU result, memory data, PC+4 and write-back data
NRegBits, 5, register-file index width

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
Flush  input  1  synchronous discard of all entries, including any same-cycle capture
InValid  input  1  MEM stage presents a valid instruction
InReady  output  1  stage can accept; registered
RegWrite  input  1  instruction writes the register file
MemtoReg  input  1  write-back value comes from memory data
LinkControl  input  1  jal/jalr; write-back value is PC_4 (overrides MemtoReg)
WriteRegister  input  NRegBits  destination register index
ALUResult  input  NBits  ALU result from MEM
MemoryData  input  NBits  data-memory read data from MEM
PC_4  input  NBits  PC+4 of the instruction
OutValid  output  1  WB entry valid
OutReady  input  1  WB side consumes the entry this cycle
RegWriteOut  output  1  register-file write enable
WriteRegisterOut  output  NRegBits  register-file write index
WriteBackData  output  NBits  register-file write data
RetiredCount  output  32  number of retired instructions (see Optional Feature)

Behaviour:
- Storage: a main entry (drives the outputs) and a skid entry. Each entry holds {RegWrite, WriteRegister, WriteBackData}.
- WriteBackData is selected at capture time: LinkControl ? PC_4 : (MemtoReg ? MemoryData : ALUResult). The selected value is stored; it is not recomputed at the output.
- Accept = InValid & InReady. Drain = OutValid & OutReady.
- InReady = ~skid_valid. It is a flop output with no combinational dependence on OutReady.
- Reset is asynchronous and active-low. While reset=0, all entries are invalid and all data is zero. OutValid=0, RegWriteOut=0, WriteRegisterOut=0, WriteBackData=0, InReady=1, RetiredCount=0. Reset mid-operation drops all entries immediately.
- State machine (occupancy):
  - EMPTY: on Accept, the capture goes to main and the state moves to ONE. Latency is 1 cycle from capture to OutValid.
  - ONE, Accept and Drain together: the new capture replaces main; stay in ONE.
  - ONE, Accept only: the capture goes to skid; move to FULL, and InReady drops next cycle.
  - ONE, Drain only: move to EMPTY.
  - ONE, neither: hold.
  - FULL: InReady=0, so no accept. On Drain, skid moves to main and the state moves to ONE. Otherwise hold.
- Flush has highest priority after reset. The next state is EMPTY, both entries are invalidated, and any same-cycle Accept is discarded. A same-cycle Drain still counts as retired.
- RegWriteOut = OutValid & main.RegWrite & (main.WriteRegister != 0). Writes to $zero are suppressed, but the entry still occupies and drains normally.
- While OutValid=0, WriteRegisterOut and WriteBackData hold their last value. Consumers use OutValid/RegWriteOut as qualifiers.
- Entry order is strictly FIFO. No entry is duplicated or lost except by Flush or reset.

Optional Feature:
RETIRE_COUNTER_EN
- Defined: RetiredCount is a 32-bit register. It increments by 1 on every Drain cycle, wraps from 0xFFFF_FFFF to 0, is cleared only by reset (not by Flush), and counts $zero-suppressed entries.
- Undefined: RetiredCount is tied to 0 and no counter flops are built.

Test Plan:
- Reset then single load: InValid=1, MemtoReg=1, WriteRegister=8, MemoryData=0x0000_00AA, OutReady=1. Expect OutValid=1 the next cycle, RegWriteOut=1, WriteRegisterOut=8, WriteBackData=0x0000_00AA.
- Link priority: LinkControl=1, MemtoReg=1, PC_4=0x0040_0010, WriteRegister=31. Expect WriteBackData=0x0040_0010.
- Back-pressure: OutReady=0, two accepts (ALUResult 0x11 then 0x22). Expect InReady=0 after the second. Then OutReady=1: expect 0x11 then 0x22 on consecutive cycles and InReady=1 again.
- $zero write: RegWrite=1, WriteRegister=0, ALUResult=0x5. Expect OutValid=1 and RegWriteOut=0. With RETIRE_COUNTER_EN, RetiredCount increments by 1.
- Flush while FULL and with InValid=1 in the same cycle: expect OutValid=0 and InReady=1 the next cycle, and the flushed/new data never appears.
- Async reset asserted mid-stream: OutValid, RegWriteOut and RetiredCount go to 0 without a clock edge. Normal accept resumes after reset deasserts.

Source files
------------

// File: rtl/mem_wb_pipeline_stage.sv
// rtl/mem_wb_pipeline_stage.sv - MEM/WB pipeline register with two-entry skid buffer and flush.
// Optional retired-instruction counter enabled by defining RETIRE_COUNTER_EN.
module mem_wb_pipeline_stage #(
    parameter int NBits    = 32,
    parameter int NRegBits = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                Flush,
    input  logic                InValid,
    output logic                InReady,
    input  logic                RegWrite,
    input  logic                MemtoReg,
    input  logic                LinkControl,
    input  logic [NRegBits-1:0] WriteRegister,
    input  logic [NBits-1:0]    ALUResult,
    input  logic [NBits-1:0]    MemoryData,
    input  logic [NBits-1:0]    PC_4,
    output logic                OutValid,
    input  logic                OutReady,
    output logic                RegWriteOut,
    output logic [NRegBits-1:0] WriteRegisterOut,
    output logic [NBits-1:0]    WriteBackData,
    output logic [31:0]         RetiredCount
);

    typedef enum logic [1:0] {
        stEmpty = 2'd0,
        stOne   = 2'd1,
        stFull  = 2'd2
    } occState_t;

    occState_t             state;
    occState_t             nextState;
    logic                  inReadyQ;
    logic                  accept;
    logic                  drain;
    logic                  loadMainIn;
    logic                  loadMainSkid;
    logic                  loadSkid;
    logic [NBits-1:0]      selData;

    logic                  mainRegWrite;
    logic [NRegBits-1:0]   mainWriteReg;
    logic [NBits-1:0]      mainData;
    logic                  skidRegWrite;
    logic [NRegBits-1:0]   skidWriteReg;
    logic [NBits-1:0]      skidData;

    assign selData  = LinkControl ? PC_4 : (MemtoReg ? MemoryData : ALUResult);
    assign OutValid = (state != stEmpty);
    assign InReady  = inReadyQ;
    assign accept   = InValid & inReadyQ;
    assign drain    = OutValid & OutReady;

    always_comb begin
        nextState    = state;
        loadMainIn   = 1'b0;
        loadMainSkid = 1'b0;
        loadSkid     = 1'b0;
        if (Flush) begin
            nextState = stEmpty;
        end else begin
            case (state)
                stEmpty: begin
                    if (accept) begin
                        loadMainIn = 1'b1;
                        nextState  = stOne;
                    end
                end
                stOne: begin
                    if (accept && drain) begin
                        loadMainIn = 1'b1;
                    end else if (accept) begin
                        loadSkid  = 1'b1;
                        nextState = stFull;
                    end else if (drain) begin
                        nextState = stEmpty;
                    end
                end
                stFull: begin
                    if (drain) begin
                        loadMainSkid = 1'b1;
                        nextState    = stOne;
                    end
                end
                default: nextState = stEmpty;
            endcase
        end
    end

    // Ready is registered from the next occupancy so it never sees OutReady combinationally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= stEmpty;
            inReadyQ <= 1'b1;
        end else begin
            state    <= nextState;
            inReadyQ <= (nextState != stFull);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mainRegWrite <= 1'b0;
            mainWriteReg <= '0;
            mainData     <= '0;
            skidRegWrite <= 1'b0;
            skidWriteReg <= '0;
            skidData     <= '0;
        end else begin
            if (loadMainIn) begin
                mainRegWrite <= RegWrite;
                mainWriteReg <= WriteRegister;
                mainData     <= selData;
            end else if (loadMainSkid) begin
                mainRegWrite <= skidRegWrite;
                mainWriteReg <= skidWriteReg;
                mainData     <= skidData;
            end
            if (loadSkid) begin
                skidRegWrite <= RegWrite;
                skidWriteReg <= WriteRegister;
                skidData     <= selData;
            end
        end
    end

    // $zero writes still occupy and drain; only the write enable is masked.
    assign RegWriteOut      = OutValid & mainRegWrite & (mainWriteReg != '0);
    assign WriteRegisterOut = mainWriteReg;
    assign WriteBackData    = mainData;

`ifdef RETIRE_COUNTER_EN
    logic [31:0] retiredQ;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retiredQ <= '0;
        end else if (drain) begin
            retiredQ <= retiredQ + 32'd1;
        end
    end

    assign RetiredCount = retiredQ;
`else
    assign RetiredCount = 32'd0;
`endif

endmodule

// File: tb/tb_mem_wb_pipeline_stage.sv
// tb/tb_mem_wb_pipeline_stage.sv - randomized queue-model bench for mem_wb_pipeline_stage.
module tb_mem_wb_pipeline_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        Flush;
    logic        InValid;
    logic        InReady;
    logic        RegWrite;
    logic        MemtoReg;
    logic        LinkControl;
    logic [4:0]  WriteRegister;
    logic [31:0] ALUResult;
    logic [31:0] MemoryData;
    logic [31:0] PC_4;
    logic        OutValid;
    logic        OutReady;
    logic        RegWriteOut;
    logic [4:0]  WriteRegisterOut;
    logic [31:0] WriteBackData;
    logic [31:0] RetiredCount;

    always #5 clk = ~clk;

    mem_wb_pipeline_stage #(.NBits(32), .NRegBits(5)) dut (
        .clk(clk), .reset(reset), .Flush(Flush), .InValid(InValid), .InReady(InReady),
        .RegWrite(RegWrite), .MemtoReg(MemtoReg), .LinkControl(LinkControl),
        .WriteRegister(WriteRegister), .ALUResult(ALUResult), .MemoryData(MemoryData),
        .PC_4(PC_4), .OutValid(OutValid), .OutReady(OutReady), .RegWriteOut(RegWriteOut),
        .WriteRegisterOut(WriteRegisterOut), .WriteBackData(WriteBackData),
        .RetiredCount(RetiredCount)
    );

    typedef struct packed {
        logic        rw;
        logic [4:0]  wr;
        logic [31:0] data;
    } entry_t;

    entry_t      modelQ[$];
    entry_t      lastShown;
    entry_t      newEntry;
    entry_t      curEntry;
    logic [31:0] modelCount;
    logic        mDrain;
    logic        mAccept;
    logic        expValid;
    logic [31:0] expCount;
    logic        cmpEn = 1'b0;
    int          checks = 0;
    int          failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a bounded FIFO of at most two entries, updated once per clock.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            modelQ.delete();
            lastShown  = '0;
            modelCount = '0;
        end else begin
            mDrain  = (modelQ.size() != 0) && OutReady;
            mAccept = InValid && (modelQ.size() < 2);
            newEntry.rw   = RegWrite;
            newEntry.wr   = WriteRegister;
            newEntry.data = LinkControl ? PC_4 : (MemtoReg ? MemoryData : ALUResult);
            if (mDrain) modelCount = modelCount + 32'd1;
            if (Flush) begin
                modelQ.delete();
            end else begin
                if (mDrain) void'(modelQ.pop_front());
                if (mAccept) modelQ.push_back(newEntry);
            end
            if (modelQ.size() != 0) lastShown = modelQ[0];
        end
    end

    always @(negedge clk) begin
        if (cmpEn) begin
            expValid = (modelQ.size() != 0);
            if (expValid) curEntry = modelQ[0];
            else curEntry = lastShown;
`ifdef RETIRE_COUNTER_EN
            expCount = modelCount;
`else
            expCount = 32'd0;
`endif
            check("OutValid", 32'(OutValid), 32'(expValid));
            check("InReady", 32'(InReady), 32'(modelQ.size() < 2));
            check("RegWriteOut", 32'(RegWriteOut),
                  32'(expValid && curEntry.rw && (curEntry.wr != 5'd0)));
            check("WriteRegisterOut", 32'(WriteRegisterOut), 32'(curEntry.wr));
            check("WriteBackData", WriteBackData, curEntry.data);
            check("RetiredCount", RetiredCount, expCount);
        end
    end

    task automatic idle(input logic ready);
        InValid       = 1'b0;
        Flush         = 1'b0;
        RegWrite      = 1'b0;
        MemtoReg      = 1'b0;
        LinkControl   = 1'b0;
        WriteRegister = 5'd0;
        ALUResult     = 32'd0;
        MemoryData    = 32'd0;
        PC_4          = 32'd0;
        OutReady      = ready;
    endtask

    task automatic aluInput(input logic [4:0] wr, input logic [31:0] val);
        InValid       = 1'b1;
        RegWrite      = 1'b1;
        MemtoReg      = 1'b0;
        LinkControl   = 1'b0;
        WriteRegister = wr;
        ALUResult     = val;
    endtask

    task automatic randomInputs();
        InValid       = ($urandom_range(0, 3) != 0);
        OutReady      = ($urandom_range(0, 2) != 0);
        Flush         = ($urandom_range(0, 24) == 0);
        RegWrite      = ($urandom_range(0, 3) != 0);
        MemtoReg      = $urandom_range(0, 1) == 1;
        LinkControl   = ($urandom_range(0, 5) == 0);
        WriteRegister = 5'($urandom_range(0, 31));
        ALUResult     = $urandom;
        MemoryData    = $urandom;
        PC_4          = $urandom;
    endtask

    logic [31:0] countBefore;

    initial begin
        reset = 1'b0;
        idle(1'b1);
        repeat (2) @(negedge clk);
        check("reset OutValid", 32'(OutValid), 32'd0);
        check("reset InReady", 32'(InReady), 32'd1);
        check("reset RegWriteOut", 32'(RegWriteOut), 32'd0);
        check("reset WriteRegisterOut", 32'(WriteRegisterOut), 32'd0);
        check("reset WriteBackData", WriteBackData, 32'd0);
        check("reset RetiredCount", RetiredCount, 32'd0);
        reset = 1'b1;
        cmpEn = 1'b1;

        InValid = 1'b1; RegWrite = 1'b1; MemtoReg = 1'b1;
        WriteRegister = 5'd8; MemoryData = 32'h0000_00AA;
        @(negedge clk);
        check("load OutValid", 32'(OutValid), 32'd1);
        check("load RegWriteOut", 32'(RegWriteOut), 32'd1);
        check("load WriteRegisterOut", 32'(WriteRegisterOut), 32'd8);
        check("load WriteBackData", WriteBackData, 32'h0000_00AA);
        idle(1'b1);

        @(negedge clk);
        InValid = 1'b1; RegWrite = 1'b1; MemtoReg = 1'b1; LinkControl = 1'b1;
        PC_4 = 32'h0040_0010; MemoryData = 32'hDEAD_BEEF; WriteRegister = 5'd31;
        @(negedge clk);
        check("link WriteBackData", WriteBackData, 32'h0040_0010);
        check("link WriteRegisterOut", 32'(WriteRegisterOut), 32'd31);
        idle(1'b1);

        @(negedge clk);
        idle(1'b0);
        aluInput(5'd3, 32'h11);
        @(negedge clk);
        aluInput(5'd3, 32'h22);
        @(negedge clk);
        check("bp InReady low", 32'(InReady), 32'd0);
        check("bp first data", WriteBackData, 32'h11);
        idle(1'b1);
        @(negedge clk);
        check("bp second data", WriteBackData, 32'h22);
        check("bp InReady high", 32'(InReady), 32'd1);
        @(negedge clk);
        check("bp drained", 32'(OutValid), 32'd0);

        aluInput(5'd0, 32'h5);
        @(negedge clk);
        check("zero OutValid", 32'(OutValid), 32'd1);
        check("zero RegWriteOut", 32'(RegWriteOut), 32'd0);
        countBefore = RetiredCount;
        idle(1'b1);
        @(negedge clk);
`ifdef RETIRE_COUNTER_EN
        check("zero RetiredCount", RetiredCount, 32'd5);
        check("zero RetiredCount step", RetiredCount, countBefore + 32'd1);
`else
        check("zero RetiredCount", RetiredCount, 32'd0);
`endif

        idle(1'b0);
        aluInput(5'd4, 32'h33);
        @(negedge clk);
        aluInput(5'd4, 32'h44);
        @(negedge clk);
        Flush = 1'b1;
        aluInput(5'd4, 32'h99);
        @(negedge clk);
        check("flush OutValid", 32'(OutValid), 32'd0);
        check("flush InReady", 32'(InReady), 32'd1);
        check("flush held data", WriteBackData, 32'h33);
        idle(1'b1);
        repeat (2) @(negedge clk);
        check("flush no resurrect", 32'(OutValid), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            randomInputs();
            if (i == 1500) begin
                @(posedge clk);
                #2 reset = 1'b0;
                #1;
                check("async OutValid", 32'(OutValid), 32'd0);
                check("async RegWriteOut", 32'(RegWriteOut), 32'd0);
                check("async RetiredCount", RetiredCount, 32'd0);
                check("async InReady", 32'(InReady), 32'd1);
                @(negedge clk);
                reset = 1'b1;
            end else begin
                @(negedge clk);
            end
        end

        idle(1'b1);
        repeat (4) @(negedge clk);
        cmpEn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
